pipe_adder: RTL

//   Parametrised, pipelined two-operand adder/subtractor with valid/ready handshake on both sides.

---
 rtl/adder_pkg.sv | 30 +++
 rtl/add_slice.sv | 29 ++
 rtl/pipe_adder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared types and sizing helpers for the pipelined adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // Width of one carry segment; WIDTH must be an exact multiple of STAGES.
  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Bit position of the least significant bit of segment k.
  function automatic int seg_lsb(input int k, input int seg);
    return k * seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/add_slice.sv
// ============================================================================
// Module   : add_slice
// Brief    : Combinational SEG-bit adder segment with carry out and MSB carry-in.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_slice #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_msb_cin
);

  logic [SEG:0] w_total;

  assign w_total   = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_cin};
  assign o_sum     = w_total[SEG-1:0];
  assign o_cout    = w_total[SEG];
  // Recover the carry into the top bit; XOR with carry out gives signed overflow.
  assign o_msb_cin = i_a[SEG-1] ^ i_b[SEG-1] ^ w_total[SEG-1];

endmodule

`default_nettype wire

// File: rtl/pipe_adder.sv
// ============================================================================
// Module   : pipe_adder
// Brief    : Pipelined WIDTH-bit adder/subtractor, one carry segment per stage,
//            valid/ready on both sides. Define PIPE_ADDER_SAT_EN to clamp
//            overflowing results to the signed limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  op_e              op,
  input  logic             i_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int SEG  = seg_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] r_carry;
  logic [STAGES-1:0] w_load;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  // Signed overflow of the partial result held by each stage.
  logic              r_ovf [STAGES];

  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin_eff;
  logic [WIDTH-1:0]  w_raw;
  logic [WIDTH-1:0]  w_res;

  assign w_b_eff   = (op == OP_SUB) ? ~B : B;
  assign w_cin_eff = (op == OP_SUB) ? 1'b1 : i_carry;

  // Backpressure ripples from the consumer down to the input.
  always_comb begin
    logic [STAGES-1:0] v_load;
    v_load       = '0;
    v_load[LAST] = ~r_valid[LAST] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      v_load[k] = ~r_valid[k] | v_load[k+1];
    end
    w_load = v_load;
  end

  assign in_ready = w_load[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LSB = seg_lsb(k, SEG);

    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_sum_in;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_cin;
    logic             w_valid_in;
    logic [SEG-1:0]   w_seg_sum;
    logic             w_seg_cout;
    logic             w_seg_msb_cin;

    if (k == 0) begin : g_head
      assign w_a_in     = A;
      assign w_b_in     = w_b_eff;
      assign w_sum_in   = '0;
      assign w_cin      = w_cin_eff;
      assign w_valid_in = in_valid;
    end else begin : g_body
      assign w_a_in     = r_a[k-1];
      assign w_b_in     = r_b[k-1];
      assign w_sum_in   = r_sum[k-1];
      assign w_cin      = r_carry[k-1];
      assign w_valid_in = r_valid[k-1];
    end

    add_slice #(
      .SEG (SEG)
    ) u_slice (
      .i_a       (w_a_in[LSB +: SEG]),
      .i_b       (w_b_in[LSB +: SEG]),
      .i_cin     (w_cin),
      .o_sum     (w_seg_sum),
      .o_cout    (w_seg_cout),
      .o_msb_cin (w_seg_msb_cin)
    );

    always_comb begin
      w_sum_nxt              = w_sum_in;
      w_sum_nxt[LSB +: SEG]  = w_seg_sum;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid[k] <= 1'b0;
        r_carry[k] <= 1'b0;
        r_ovf[k]   <= 1'b0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
        r_sum[k]   <= '0;
      end else if (w_load[k]) begin
        r_valid[k] <= w_valid_in;
        r_carry[k] <= w_seg_cout;
        r_ovf[k]   <= w_seg_cout ^ w_seg_msb_cin;
        r_a[k]     <= w_a_in;
        r_b[k]     <= w_b_in;
        r_sum[k]   <= w_sum_nxt;
      end
    end
  end

  assign w_raw = r_sum[LAST];

`ifdef PIPE_ADDER_SAT_EN
  // A wrapped result has the wrong sign bit, so the clamp direction is its inverse.
  assign w_res = r_ovf[LAST] ? {~w_raw[WIDTH-1], {(WIDTH-1){w_raw[WIDTH-1]}}} : w_raw;
`else
  assign w_res = w_raw;
`endif

  assign out_valid = r_valid[LAST];
  assign out       = r_valid[LAST] ? w_res : '0;
  assign o_carry   = r_valid[LAST] & r_carry[LAST];
  assign o_ovf     = r_valid[LAST] & r_ovf[LAST];
  assign o_zero    = r_valid[LAST] & (w_res == '0);

endmodule

`default_nettype wire
